iomem_interconnect: RTL

- Parametrised successor to the hand-written iomem page decoder and ready/rdata mux in the SoC top level.
- Sits between the picosoc iomem master port and up to NUM_SLAVES peripherals (gpio, audio, video, sdcard, i2c, flash, ...).
- Decodes addr[31:24] into slave pages and registers the response.
- Selects rdata by latched slave index, not by ready.
- Adds a per-access timeout, an unmapped-access response, sticky error status and an error interrupt.

---
 rtl/iomem_pkg.sv | 32 +++
 rtl/iomem_timeout.sv | 29 ++
 rtl/iomem_interconnect.sv | 134 +++++++++++++
 3 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem interconnect: FSM encoding, page width,
// status register layout and the default error read data.
package iomem_pkg;

    localparam int PAGE_W = 8;

    // Status register layout
    localparam int ST_TIMEOUT_BIT  = 0;
    localparam int ST_UNMAPPED_BIT = 1;
    localparam int ST_PAGE_LSB     = 2;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Status word: {22'b0, last_err_page, unmapped_flag, timeout_flag}
    function automatic logic [31:0] status_word(input logic [PAGE_W-1:0] last_page,
                                                input logic unmapped,
                                                input logic timeout);
        logic [31:0] w;
        w = '0;
        w[ST_TIMEOUT_BIT]                      = timeout;
        w[ST_UNMAPPED_BIT]                     = unmapped;
        w[ST_PAGE_LSB +: PAGE_W]               = last_page;
        return w;
    endfunction

endpackage

// File: rtl/iomem_timeout.sv
// Access watchdog: counts cycles while enabled, clears on request and flags
// the last permitted cycle so the FSM can abort on it.
module iomem_timeout #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Clear has priority over counting so each access starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expire = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/iomem_interconnect.sv
// iomem page decoder and response mux: routes master accesses to slave pages,
// serves the status register, answers unmapped pages and aborts slow slaves.
module iomem_interconnect
    import iomem_pkg::*;
#(
    parameter int          NUM_SLAVES     = 8,
    parameter logic [7:0]  SLAVE_BASE     = 8'h03,
    parameter logic [7:0]  STATUS_PAGE    = 8'h0F,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [3:0]               m_wstrb,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    output logic [31:0]              m_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic                     err_irq
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic               timeout_flag;
    logic               unmapped_flag;
    logic [PAGE_W-1:0]  last_err_page;
    logic               expire;

    logic [PAGE_W-1:0]  page;
    logic [PAGE_W:0]    page_off;
    logic               in_range;
    logic               status_clr;
    logic [31:0]        slave_rdata [NUM_SLAVES];

    // Only the page byte, strobe bit 0 and data bit 0 are decoded here
    logic unused_bus;
    assign unused_bus = ^{m_addr[23:0], m_wstrb[3:1], m_wdata[31:1]};

    assign page       = m_addr[31:24];
    assign page_off   = {1'b0, page} - {1'b0, SLAVE_BASE};
    assign in_range   = ({1'b0, page} >= {1'b0, SLAVE_BASE}) &&
                        ({1'b0, page} <  ({1'b0, SLAVE_BASE} + (PAGE_W+1)'(NUM_SLAVES)));
    assign status_clr = m_wstrb[0] && m_wdata[0];

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rd
        assign slave_rdata[i] = s_rdata[32*i +: 32];
    end

    iomem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (resetn),
        .clr    (state != S_WAIT),
        .en     (state == S_WAIT),
        .expire (expire)
    );

    // Request goes only to the latched slave, and only while waiting on it
    always_comb begin
        s_valid = '0;
        if (state == S_WAIT) s_valid[sel] = 1'b1;
    end

    // Access FSM with registered response, sticky error flags and irq
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            sel           <= '0;
            m_ready       <= 1'b0;
            m_rdata       <= '0;
            timeout_flag  <= 1'b0;
            unmapped_flag <= 1'b0;
            last_err_page <= '0;
            err_irq       <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            err_irq <= timeout_flag | unmapped_flag;
            case (state)
                S_IDLE: begin
                    if (m_valid) begin
                        if (in_range) begin
                            sel   <= page_off[SEL_W-1:0];
                            state <= S_WAIT;
                        end else if (page == STATUS_PAGE) begin
                            m_rdata <= status_word(last_err_page, unmapped_flag, timeout_flag);
                            if (status_clr) begin
                                timeout_flag  <= 1'b0;
                                unmapped_flag <= 1'b0;
                            end
                            m_ready <= 1'b1;
                            state   <= S_RESP;
                        end else begin
                            m_rdata       <= '0;
                            unmapped_flag <= 1'b1;
                            last_err_page <= page;
                            m_ready       <= 1'b1;
                            state         <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (!m_valid) begin
                        // Master withdrew the request: drop it silently
                        state <= S_IDLE;
                    end else if (s_ready[sel]) begin
                        m_rdata <= slave_rdata[sel];
                        m_ready <= 1'b1;
                        state   <= S_RESP;
                    end else if (expire) begin
                        m_rdata       <= ERR_RDATA;
                        timeout_flag  <= 1'b1;
                        last_err_page <= SLAVE_BASE + PAGE_W'(sel);
                        m_ready       <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
